wbu: RTL and testbench
======================

// Module: wbu
// PURPOSE
//  Write-back stage, directly downstream of the LSU. Accepts one retiring instruction per
//  LSU valid pulse and registers its result bundle. Issues a one-cycle GPR/CSR write strobe,
//  and on ecall also writes mcause. Then hands the next PC to the IFU over a valid/ready handshake.
// PARAMETERS
//  NR_REG      32   GPR count; rd is log2(NR_REG) bits; x0 is never written
//  MCAUSE_ECALL 11  value written to mcause on ecall (M-mode environment call)
// PORTS
//  clk               in   1   clock; all state updates on posedge
//  rst               in   1   asynchronous, active-low reset (0 = reset)
//  wbu_receive_valid in   1   LSU valid pulse; bundle inputs below are valid only this cycle
//  wd                in   32  GPR write data
//  csr_wd            in   32  CSR write data
//  rd                in   5   GPR destination
//  csr_rd            in   2   CSR dest: 00 mstatus, 01 mtvec, 10 mepc, 11 mcause
//  reg_write_en      in   1   GPR write request
//  csreg_write_en    in   1   CSR write request
//  ecall             in   1   instruction is ecall
//  pc_next           in   32  next fetch PC
//  ifu_receive_ready in   1   IFU can take dnpc
//  wbu_send_ready    out  1   one-cycle pulse: bundle accepted
//  rf_wen/rf_waddr/rf_wdata    out 1/5/32   GPR write port
//  csr_wen/csr_waddr/csr_wdata out 1/2/32   CSR write port
//  mcause_wen/mcause_wdata     out 1/32     dedicated mcause port for ecall
//  wbu_send_valid    out  1   dnpc valid to IFU
//  dnpc              out  32  next PC to IFU
//  overrun_err       out  1   sticky: valid arrived while not IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; every output and internal latch is 0.
//  - States: IDLE -> COMMIT -> SEND -> IDLE. All outputs are registered.
//  - IDLE, wbu_receive_valid=1 (cycle T):
//      latch the bundle; state<=COMMIT; wbu_send_ready=1 during T+1 only.
//  - IDLE without valid: everything holds, with all strobes at 0.
//  - COMMIT (cycle T+1): drive the write strobes from the latched bundle for exactly this cycle.
//      rf_wen=reg_write_en & (rd!=0).
//      csr_wen=csreg_write_en.
//      mcause_wen=ecall, with mcause_wdata=MCAUSE_ECALL.
//      State<=SEND.
//  - ecall with csreg_write_en and csr_rd=11: csr port is suppressed; mcause port wins.
//  - SEND (from T+2): wbu_send_valid=1; dnpc=latched pc_next.
//      Both hold stable until ifu_receive_ready is sampled 1.
//      On that edge: valid drops and state<=IDLE.
//      Minimum accept-to-accept spacing is 3 cycles.
//  - ifu_receive_ready already 1 on entry to SEND: handshake completes on the first SEND edge.
//  - wbu_receive_valid while in COMMIT/SEND: the bundle is dropped, never queued.
//      overrun_err<=1 and stays 1 until reset.
//  - Reset mid-operation: all strobes and valid drop immediately; the latched bundle is discarded.
// CONFIGURATION
//  WBU_INSTRET_EN defined:
//      adds output instret[63:0]; reset 0.
//      +1 on each COMMIT cycle; wraps 2^64-1 -> 0.
//  WBU_INSTRET_EN undefined:
//      port and counter absent; all other behaviour identical.
// TESTING
//  1. ALU op: valid, rd=5, wd=0x1234, reg_write_en=1, pc_next=0x80000004.
//     -> T+1 rf_wen=1, waddr=5, wdata=0x1234.
//     -> T+2 wbu_send_valid=1, dnpc=0x80000004.
//  2. rd=0 with reg_write_en=1 -> rf_wen stays 0; dnpc handshake still occurs.
//  3. ecall: csr_rd=10, csr_wd=0x80000100, csreg_write_en=1.
//     -> T+1 csr_wen=1 to mepc, mcause_wen=1, mcause_wdata=11.
//  4. Hold ifu_receive_ready=0 for 5 cycles.
//     -> valid/dnpc stable 5 cycles; drops the cycle after ready=1; second valid is then accepted.
//  5. Pulse valid during SEND.
//     -> no extra write strobe; overrun_err=1 persists until rst=0.
//  6. Assert rst=0 mid-COMMIT -> outputs 0 asynchronously.
//     With WBU_INSTRET_EN: instret=0 after reset; 3 retirements -> 3.

Source files
------------

// File: rtl/wbu_if.sv
// wbu_if: signal bundle of the write-back stage.
//   LSU -> WBU : retiring-instruction bundle, qualified by wbu_receive_valid.
//   WBU -> RF  : GPR write port, CSR write port, dedicated mcause port.
//   WBU -> IFU : next-PC (dnpc) handshake.
//
// Handshake rules:
//   * wbu_receive_valid is a one-cycle pulse. The bundle fields are only meaningful
//     in that cycle. There is no back-pressure toward the LSU. A pulse that arrives
//     while the stage is busy is dropped and flagged on overrun_err.
//     wbu_send_ready pulses for one cycle, in the cycle after a pulse was taken.
//   * wbu_send_valid/dnpc toward the IFU follow valid/ready rules. Once valid is
//     raised, valid and dnpc stay stable until a rising edge where ifu_receive_ready
//     is 1. That edge is the transfer, and valid drops after it. The ready signal may
//     already be high before valid rises.
//
// state_dbg exposes the FSM state (0 IDLE, 1 COMMIT, 2 SEND).
// Optional feature macro: WBU_INSTRET_EN adds the 64-bit instret counter.
interface wbu_if #(
  parameter int NR_REG = 32
);
  localparam int RW = $clog2(NR_REG);

  // LSU -> WBU bundle
  logic          wbu_receive_valid;
  logic [31:0]   wd;
  logic [31:0]   csr_wd;
  logic [RW-1:0] rd;
  logic [1:0]    csr_rd;
  logic          reg_write_en;
  logic          csreg_write_en;
  logic          ecall;
  logic [31:0]   pc_next;

  // IFU -> WBU
  logic          ifu_receive_ready;

  // WBU outputs
  logic          wbu_send_ready;
  logic          rf_wen;
  logic [RW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  logic          csr_wen;
  logic [1:0]    csr_waddr;
  logic [31:0]   csr_wdata;
  logic          mcause_wen;
  logic [31:0]   mcause_wdata;
  logic          wbu_send_valid;
  logic [31:0]   dnpc;
  logic          overrun_err;
  logic [1:0]    state_dbg;
`ifdef WBU_INSTRET_EN
  logic [63:0]   instret;
`endif

  // Write-back stage side
  modport slave (
    input  wbu_receive_valid, wd, csr_wd, rd, csr_rd,
    input  reg_write_en, csreg_write_en, ecall, pc_next,
    input  ifu_receive_ready,
    output wbu_send_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output csr_wen, csr_waddr, csr_wdata,
    output mcause_wen, mcause_wdata,
    output wbu_send_valid, dnpc,
    output overrun_err, state_dbg
`ifdef WBU_INSTRET_EN
    , output instret
`endif
  );

  // LSU / IFU / register-file side
  modport master (
    output wbu_receive_valid, wd, csr_wd, rd, csr_rd,
    output reg_write_en, csreg_write_en, ecall, pc_next,
    output ifu_receive_ready,
    input  wbu_send_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  csr_wen, csr_waddr, csr_wdata,
    input  mcause_wen, mcause_wdata,
    input  wbu_send_valid, dnpc,
    input  overrun_err, state_dbg
`ifdef WBU_INSTRET_EN
    , input instret
`endif
  );
endinterface

// File: rtl/wbu.sv
// wbu: write-back stage, directly downstream of the LSU.
//   IDLE   : wait for an LSU valid pulse; on it, latch the bundle.
//   COMMIT : one cycle of GPR / CSR / mcause write strobes from the latched bundle.
//   SEND   : present dnpc to the IFU until it is accepted, then return to IDLE.
// Every output is a flop, so the strobes seen in COMMIT are loaded on the accept edge.
// This gives a minimum spacing of 3 cycles between two accepted bundles.
// Optional feature macro: WBU_INSTRET_EN adds instret[63:0]. The counter advances once
// per COMMIT cycle and wraps at 2^64.
module wbu #(
  parameter int          NR_REG       = 32,
  parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
  input  logic clk,
  input  logic rst,
  wbu_if.slave bus
);

  localparam int         RW         = $clog2(NR_REG);
  localparam logic [1:0] CSR_MCAUSE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Decoded events of the current cycle
  logic accept;       // bundle taken in IDLE
  logic handshake;    // dnpc transferred to the IFU on this edge
  logic overrun;      // valid pulse arrived while busy, so it is dropped

  // Decoded write requests of the incoming bundle
  logic rd_is_x0;
  logic rf_req;
  logic csr_req;
  logic csr_hits_mcause;

  // PC of the latched bundle, held until it is presented in SEND
  logic [31:0] pc_q;

  assign rd_is_x0        = (bus.rd == {RW{1'b0}});
  assign rf_req          = bus.reg_write_en & ~rd_is_x0;
  // An ecall owns mcause, so a CSR write aimed at mcause in the same instruction is dropped.
  assign csr_hits_mcause = bus.ecall & (bus.csr_rd == CSR_MCAUSE);
  assign csr_req         = bus.csreg_write_en & ~csr_hits_mcause;

  assign bus.state_dbg   = state_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and cycle events
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    handshake = 1'b0;
    overrun   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wbu_receive_valid) begin
          accept  = 1'b1;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        overrun = bus.wbu_receive_valid;
        state_d = SEND;
      end
      SEND: begin
        overrun = bus.wbu_receive_valid;
        if (bus.ifu_receive_ready) begin
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-cycle strobes: set on the accept edge so they are high exactly during COMMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wbu_send_ready <= 1'b0;
      bus.rf_wen         <= 1'b0;
      bus.csr_wen        <= 1'b0;
      bus.mcause_wen     <= 1'b0;
    end else begin
      bus.wbu_send_ready <= accept;
      bus.rf_wen         <= accept & rf_req;
      bus.csr_wen        <= accept & csr_req;
      bus.mcause_wen     <= accept & bus.ecall;
    end
  end

  // Bundle latch: address/data outputs and the pending PC hold until the next accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_waddr     <= '0;
      bus.rf_wdata     <= '0;
      bus.csr_waddr    <= '0;
      bus.csr_wdata    <= '0;
      bus.mcause_wdata <= '0;
      pc_q             <= '0;
    end else if (accept) begin
      bus.rf_waddr  <= bus.rd;
      bus.rf_wdata  <= bus.wd;
      bus.csr_waddr <= bus.csr_rd;
      bus.csr_wdata <= bus.csr_wd;
      pc_q          <= bus.pc_next;
      if (bus.ecall) begin
        bus.mcause_wdata <= MCAUSE_ECALL;
      end
    end
  end

  // dnpc toward the IFU: raised when COMMIT ends, held until the handshake edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wbu_send_valid <= 1'b0;
      bus.dnpc           <= '0;
    end else if (state_q == COMMIT) begin
      bus.wbu_send_valid <= 1'b1;
      bus.dnpc           <= pc_q;
    end else if (handshake) begin
      bus.wbu_send_valid <= 1'b0;
    end
  end

  // Sticky overrun flag: only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.overrun_err <= 1'b0;
    end else if (overrun) begin
      bus.overrun_err <= 1'b1;
    end
  end

`ifdef WBU_INSTRET_EN
  // Retired-instruction counter: one per COMMIT cycle, wrapping naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.instret <= '0;
    end else if (state_q == COMMIT) begin
      bus.instret <= bus.instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: bench for the write-back stage. The optional WBU_INSTRET_EN feature is
// exercised when the macro is defined for the build.
module tb_wbu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  wbu_if bus ();

  wbu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // every output flattened; all-zero after reset
  logic [142:0] all_outs;
  assign all_outs = {bus.wbu_send_ready, bus.rf_wen, bus.rf_waddr, bus.rf_wdata,
                     bus.csr_wen, bus.csr_waddr, bus.csr_wdata, bus.mcause_wen,
                     bus.mcause_wdata, bus.wbu_send_valid, bus.dnpc, bus.overrun_err,
                     bus.state_dbg};

  // architectural reference model: register files as the spec defines them
  logic [31:0] exp_gpr[32];
  logic [31:0] exp_csr[4];
  int          exp_mcause_cnt;
  logic [31:0] exp_q[$];
  // what the DUT ports actually did
  logic [31:0] obs_gpr[32];
  logic [31:0] obs_csr[4];
  int          obs_mcause_cnt;
  logic [31:0] got_q[$];
  logic        mon_en = 1'b0;

  // port monitor, sampled 1 time unit after the falling edge
  always @(negedge clk) begin
    #1;
    if (rst && mon_en) begin
      if (bus.rf_wen)  obs_gpr[bus.rf_waddr] = bus.rf_wdata;
      if (bus.csr_wen) obs_csr[bus.csr_waddr] = bus.csr_wdata;
      if (bus.mcause_wen) obs_mcause_cnt++;
      if (bus.wbu_send_valid && bus.ifu_receive_ready) got_q.push_back(bus.dnpc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.wbu_receive_valid = 1'b0;
    bus.wd                = $urandom;
    bus.csr_wd            = $urandom;
    bus.rd                = 5'($urandom);
    bus.csr_rd            = 2'($urandom);
    bus.reg_write_en      = 1'($urandom_range(0, 1));
    bus.csreg_write_en    = 1'($urandom_range(0, 1));
    bus.ecall             = 1'($urandom_range(0, 1));
    bus.pc_next           = $urandom;
  endtask

  task automatic set_bundle(input logic [4:0] a_rd, input logic [31:0] a_wd, input logic a_rwe,
                            input logic [1:0] a_crd, input logic [31:0] a_cwd, input logic a_cwe,
                            input logic a_ec, input logic [31:0] a_pc);
    bus.wbu_receive_valid = 1'b1;
    bus.rd                = a_rd;
    bus.wd                = a_wd;
    bus.reg_write_en      = a_rwe;
    bus.csr_rd            = a_crd;
    bus.csr_wd            = a_cwd;
    bus.csreg_write_en    = a_cwe;
    bus.ecall             = a_ec;
    bus.pc_next           = a_pc;
  endtask

  // valid pulse in cycle T; returns at the falling edge inside T+1
  task automatic drive_bundle(input logic [4:0] a_rd, input logic [31:0] a_wd, input logic a_rwe,
                              input logic [1:0] a_crd, input logic [31:0] a_cwd, input logic a_cwe,
                              input logic a_ec, input logic [31:0] a_pc);
    @(negedge clk);
    set_bundle(a_rd, a_wd, a_rwe, a_crd, a_cwd, a_cwe, a_ec, a_pc);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (all_outs !== '0) begin n_err++; $display("FAIL reset_async_outs: got %h want 0", all_outs); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      idle_inputs();
      @(negedge clk);
      n_cmp++; if (all_outs !== '0) begin n_err++; $display("FAIL reset_idle_hold: got %h want 0", all_outs); end
    end
  endtask

  task automatic test_alu();
    bus.ifu_receive_ready = 1'b0;
    drive_bundle(5'd5, 32'h1234, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_0004);
    n_cmp++; if (bus.wbu_send_ready !== 1'b1) begin n_err++; $display("FAIL alu_send_ready: got %b want 1", bus.wbu_send_ready); end
    n_cmp++; if (bus.rf_wen !== 1'b1) begin n_err++; $display("FAIL alu_rf_wen: got %b want 1", bus.rf_wen); end
    n_cmp++; if (bus.rf_waddr !== 5'd5) begin n_err++; $display("FAIL alu_rf_waddr: got %0d want 5", bus.rf_waddr); end
    n_cmp++; if (bus.rf_wdata !== 32'h1234) begin n_err++; $display("FAIL alu_rf_wdata: got %h want 1234", bus.rf_wdata); end
    n_cmp++; if ({bus.csr_wen, bus.mcause_wen, bus.wbu_send_valid} !== 3'b000) begin n_err++; $display("FAIL alu_other_t1: got %b want 000", {bus.csr_wen, bus.mcause_wen, bus.wbu_send_valid}); end
    @(negedge clk);
    n_cmp++; if (bus.wbu_send_valid !== 1'b1) begin n_err++; $display("FAIL alu_send_valid: got %b want 1", bus.wbu_send_valid); end
    n_cmp++; if (bus.dnpc !== 32'h8000_0004) begin n_err++; $display("FAIL alu_dnpc: got %h want 80000004", bus.dnpc); end
    n_cmp++; if ({bus.rf_wen, bus.wbu_send_ready} !== 2'b00) begin n_err++; $display("FAIL alu_strobe_len: got %b want 00", {bus.rf_wen, bus.wbu_send_ready}); end
    bus.ifu_receive_ready = 1'b1;
    @(negedge clk);
    bus.ifu_receive_ready = 1'b0;
    n_cmp++; if (bus.wbu_send_valid !== 1'b0) begin n_err++; $display("FAIL alu_valid_drop: got %b want 0", bus.wbu_send_valid); end
    repeat (3) begin
      idle_inputs();
      @(negedge clk);
      n_cmp++; if ({bus.rf_wen, bus.csr_wen, bus.mcause_wen, bus.wbu_send_ready, bus.wbu_send_valid} !== 5'b0) begin n_err++; $display("FAIL idle_strobes: got %b want 0", {bus.rf_wen, bus.csr_wen, bus.mcause_wen, bus.wbu_send_ready, bus.wbu_send_valid}); end
      n_cmp++; if (bus.rf_wdata !== 32'h1234) begin n_err++; $display("FAIL idle_hold_wdata: got %h want 1234", bus.rf_wdata); end
    end
  endtask

  task automatic test_rd_zero();
    bus.ifu_receive_ready = 1'b0;
    drive_bundle(5'd0, 32'hFFFF_0000, 1'b1, 2'd1, 32'h0, 1'b0, 1'b0, 32'h8000_0040);
    n_cmp++; if (bus.rf_wen !== 1'b0) begin n_err++; $display("FAIL rd0_rf_wen: got %b want 0", bus.rf_wen); end
    n_cmp++; if (bus.wbu_send_ready !== 1'b1) begin n_err++; $display("FAIL rd0_send_ready: got %b want 1", bus.wbu_send_ready); end
    @(negedge clk);
    n_cmp++; if ({bus.wbu_send_valid, bus.dnpc} !== {1'b1, 32'h8000_0040}) begin n_err++; $display("FAIL rd0_dnpc: got %b/%h want 1/80000040", bus.wbu_send_valid, bus.dnpc); end
    bus.ifu_receive_ready = 1'b1;
    @(negedge clk);
    bus.ifu_receive_ready = 1'b0;
    n_cmp++; if (bus.wbu_send_valid !== 1'b0) begin n_err++; $display("FAIL rd0_valid_drop: got %b want 0", bus.wbu_send_valid); end
  endtask

  task automatic test_ecall();
    bus.ifu_receive_ready = 1'b1;
    drive_bundle(5'd3, 32'h0, 1'b0, 2'd2, 32'h8000_0100, 1'b1, 1'b1, 32'h8000_0200);
    n_cmp++; if ({bus.csr_wen, bus.csr_waddr} !== {1'b1, 2'd2}) begin n_err++; $display("FAIL ecall_csr_mepc: got %b/%0d want 1/2", bus.csr_wen, bus.csr_waddr); end
    n_cmp++; if (bus.csr_wdata !== 32'h8000_0100) begin n_err++; $display("FAIL ecall_csr_wdata: got %h want 80000100", bus.csr_wdata); end
    n_cmp++; if ({bus.mcause_wen, bus.mcause_wdata} !== {1'b1, 32'd11}) begin n_err++; $display("FAIL ecall_mcause: got %b/%0d want 1/11", bus.mcause_wen, bus.mcause_wdata); end
    n_cmp++; if (bus.rf_wen !== 1'b0) begin n_err++; $display("FAIL ecall_rf_wen: got %b want 0", bus.rf_wen); end
    repeat (2) @(negedge clk);
    // ecall plus CSR write to mcause: the CSR port stays quiet
    drive_bundle(5'd3, 32'h0, 1'b0, 2'd3, 32'h1357_9BDF, 1'b1, 1'b1, 32'h8000_0300);
    n_cmp++; if ({bus.csr_wen, bus.mcause_wen} !== 2'b01) begin n_err++; $display("FAIL ecall_mcause_wins: got %b want 01", {bus.csr_wen, bus.mcause_wen}); end
    repeat (2) @(negedge clk);
    // without ecall a CSR write to mcause goes through the CSR port
    drive_bundle(5'd3, 32'h0, 1'b0, 2'd3, 32'h2468_ACE0, 1'b1, 1'b0, 32'h8000_0400);
    n_cmp++; if ({bus.csr_wen, bus.csr_waddr, bus.mcause_wen} !== {1'b1, 2'd3, 1'b0}) begin n_err++; $display("FAIL csr_mcause_plain: got %b/%0d/%b want 1/3/0", bus.csr_wen, bus.csr_waddr, bus.mcause_wen); end
    repeat (2) @(negedge clk);
    bus.ifu_receive_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bus.ifu_receive_ready = 1'b0;
    drive_bundle(5'd9, 32'hA5A5_0009, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_1000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if ({bus.wbu_send_valid, bus.dnpc} !== {1'b1, 32'h8000_1000}) begin n_err++; $display("FAIL bp_hold_%0d: got %b/%h want 1/80001000", k, bus.wbu_send_valid, bus.dnpc); end
    end
    bus.ifu_receive_ready = 1'b1;
    @(negedge clk);
    bus.ifu_receive_ready = 1'b0;
    n_cmp++; if (bus.wbu_send_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b want 0", bus.wbu_send_valid); end
    set_bundle(5'd10, 32'h0000_000A, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_1004);
    @(negedge clk);
    idle_inputs();
    n_cmp++; if ({bus.wbu_send_ready, bus.rf_wen, bus.rf_waddr} !== {2'b11, 5'd10}) begin n_err++; $display("FAIL bp_second_accept: got %b%b/%0d want 11/10", bus.wbu_send_ready, bus.rf_wen, bus.rf_waddr); end
    bus.ifu_receive_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.ifu_receive_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.ifu_receive_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_bundle(5'(i + 1), 32'(i * 17), 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h9000_0000 + 32'(i * 4));
      @(negedge clk);
      idle_inputs();
      n_cmp++; if ({bus.wbu_send_ready, bus.rf_waddr} !== {1'b1, 5'(i + 1)}) begin n_err++; $display("FAIL b2b_accept_%0d: got %b/%0d want 1/%0d", i, bus.wbu_send_ready, bus.rf_waddr, i + 1); end
      @(negedge clk);
      n_cmp++; if ({bus.wbu_send_valid, bus.dnpc} !== {1'b1, 32'h9000_0000 + 32'(i * 4)}) begin n_err++; $display("FAIL b2b_dnpc_%0d: got %b/%h", i, bus.wbu_send_valid, bus.dnpc); end
      @(negedge clk);
      n_cmp++; if (bus.wbu_send_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drop_%0d: got %b want 0", i, bus.wbu_send_valid); end
    end
    n_cmp++; if (bus.overrun_err !== 1'b0) begin n_err++; $display("FAIL b2b_no_overrun: got %b want 0", bus.overrun_err); end
    bus.ifu_receive_ready = 1'b0;
  endtask

  task automatic test_overrun();
    bus.ifu_receive_ready = 1'b0;
    drive_bundle(5'd4, 32'h4444_4444, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_2000);
    @(negedge clk);
    set_bundle(5'd7, 32'hDEAD_BEEF, 1'b1, 2'd1, 32'hCAFE_0000, 1'b1, 1'b1, 32'h8000_3000);
    @(negedge clk);
    idle_inputs();
    n_cmp++; if ({bus.rf_wen, bus.csr_wen, bus.mcause_wen, bus.wbu_send_ready} !== 4'b0) begin n_err++; $display("FAIL ovr_no_strobe: got %b want 0000", {bus.rf_wen, bus.csr_wen, bus.mcause_wen, bus.wbu_send_ready}); end
    n_cmp++; if (bus.overrun_err !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", bus.overrun_err); end
    n_cmp++; if ({bus.wbu_send_valid, bus.dnpc} !== {1'b1, 32'h8000_2000}) begin n_err++; $display("FAIL ovr_dnpc_kept: got %b/%h want 1/80002000", bus.wbu_send_valid, bus.dnpc); end
    bus.ifu_receive_ready = 1'b1;
    @(negedge clk);
    bus.ifu_receive_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.wbu_send_valid, bus.state_dbg} !== 3'b000) begin n_err++; $display("FAIL ovr_dropped: got %b/%0d want 0/0", bus.wbu_send_valid, bus.state_dbg); end
    drive_bundle(5'd8, 32'h8888_8888, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h8000_4000);
    n_cmp++; if ({bus.rf_wen, bus.rf_wdata} !== {1'b1, 32'h8888_8888}) begin n_err++; $display("FAIL ovr_next_ok: got %b/%h", bus.rf_wen, bus.rf_wdata); end
    bus.ifu_receive_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.ifu_receive_ready = 1'b0;
    n_cmp++; if (bus.overrun_err !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun_err); end
    pulse_reset();
    n_cmp++; if (bus.overrun_err !== 1'b0) begin n_err++; $display("FAIL ovr_cleared: got %b want 0", bus.overrun_err); end
  endtask

  task automatic test_reset_mid();
    bus.ifu_receive_ready = 1'b0;
    drive_bundle(5'd9, 32'h9999_0000, 1'b1, 2'd1, 32'h1111_0000, 1'b1, 1'b1, 32'h8000_5000);
    n_cmp++; if ({bus.rf_wen, bus.csr_wen, bus.mcause_wen} !== 3'b111) begin n_err++; $display("FAIL rmid_pre: got %b want 111", {bus.rf_wen, bus.csr_wen, bus.mcause_wen}); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (all_outs !== '0) begin n_err++; $display("FAIL rmid_async: got %h want 0", all_outs); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.wbu_send_valid, bus.state_dbg, bus.dnpc} !== '0) begin n_err++; $display("FAIL rmid_discard: got %b/%0d/%h want 0", bus.wbu_send_valid, bus.state_dbg, bus.dnpc); end
  endtask

  task automatic test_random();
    int delay;
    logic [4:0]  r_rd;
    logic [1:0]  r_crd;
    logic [31:0] r_wd, r_cwd, r_pc;
    logic        r_rwe, r_cwe, r_ec;
    foreach (exp_gpr[i]) begin exp_gpr[i] = '0; obs_gpr[i] = '0; end
    foreach (exp_csr[i]) begin exp_csr[i] = '0; obs_csr[i] = '0; end
    exp_mcause_cnt = 0;
    obs_mcause_cnt = 0;
    exp_q.delete();
    got_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r_wd  = $urandom;
      r_rwe = 1'($urandom_range(0, 1));
      r_crd = 2'($urandom);
      r_cwd = $urandom;
      r_cwe = 1'($urandom_range(0, 1));
      r_ec  = ($urandom_range(0, 3) == 0);
      r_pc  = $urandom;
      delay = $urandom_range(0, 4);
      if (r_rwe && r_rd != 5'd0) exp_gpr[r_rd] = r_wd;
      if (r_cwe && !(r_ec && r_crd == 2'd3)) exp_csr[r_crd] = r_cwd;
      if (r_ec) exp_mcause_cnt++;
      exp_q.push_back(r_pc);
      bus.ifu_receive_ready = (delay == 0);
      drive_bundle(r_rd, r_wd, r_rwe, r_crd, r_cwd, r_cwe, r_ec, r_pc);
      n_cmp++; if (bus.wbu_send_ready !== 1'b1) begin n_err++; $display("FAIL rnd_accept_%0d: got %b want 1", i, bus.wbu_send_ready); end
      if (r_ec) begin
        n_cmp++; if (bus.mcause_wdata !== 32'd11) begin n_err++; $display("FAIL rnd_mcause_data_%0d: got %0d want 11", i, bus.mcause_wdata); end
      end
      @(negedge clk);
      for (int k = 1; k < delay; k++) begin
        @(negedge clk);
        n_cmp++; if ({bus.wbu_send_valid, bus.dnpc} !== {1'b1, r_pc}) begin n_err++; $display("FAIL rnd_hold_%0d: got %b/%h want 1/%h", i, bus.wbu_send_valid, bus.dnpc, r_pc); end
      end
      bus.ifu_receive_ready = 1'b1;
      @(negedge clk);
      bus.ifu_receive_ready = 1'b0;
      n_cmp++; if (bus.wbu_send_valid !== 1'b0) begin n_err++; $display("FAIL rnd_drop_%0d: got %b want 0", i, bus.wbu_send_valid); end
    end
    @(negedge clk);
    mon_en = 1'b0;
    for (int r = 0; r < 32; r++) begin
      n_cmp++; if (obs_gpr[r] !== exp_gpr[r]) begin n_err++; $display("FAIL rnd_gpr_x%0d: got %h want %h", r, obs_gpr[r], exp_gpr[r]); end
    end
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (obs_csr[c] !== exp_csr[c]) begin n_err++; $display("FAIL rnd_csr_%0d: got %h want %h", c, obs_csr[c], exp_csr[c]); end
    end
    n_cmp++; if (obs_mcause_cnt !== exp_mcause_cnt) begin n_err++; $display("FAIL rnd_mcause_cnt: got %0d want %0d", obs_mcause_cnt, exp_mcause_cnt); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rnd_dnpc_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL rnd_dnpc_seq: got %h want %h", g, e); end
    end
    n_cmp++; if (bus.overrun_err !== 1'b0) begin n_err++; $display("FAIL rnd_no_overrun: got %b want 0", bus.overrun_err); end
  endtask

`ifdef WBU_INSTRET_EN
  task automatic test_instret();
    pulse_reset();
    n_cmp++; if (bus.instret !== 64'd0) begin n_err++; $display("FAIL instret_reset: got %0d want 0", bus.instret); end
    bus.ifu_receive_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_bundle(5'd1, 32'(i), 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 32'h100 + 32'(i));
      repeat (2) @(negedge clk);
    end
    bus.ifu_receive_ready = 1'b0;
    n_cmp++; if (bus.instret !== 64'd3) begin n_err++; $display("FAIL instret_count: got %0d want 3", bus.instret); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    bus.ifu_receive_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_alu();
    test_rd_zero();
    test_ecall();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_random();
`ifdef WBU_INSTRET_EN
    test_instret();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
